// File: rtl/imm_datapath_controller.sv
// ============================================================================
// Module      : imm_datapath_controller
// Description : Multi-cycle control FSM that sequences fetch/decode/execute/
//               memory/writeback and drives datapath enables and selects.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imm_datapath_controller #(
    parameter int MEM_WAIT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        ALU_zero,
    output logic        PC_LdEn,
    output logic        PC_sel,
    output logic        IR_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic [1:0]  ImmExt_sel,
    output logic        MEM_WrEn,
    output logic        ByteOp
);

    localparam logic [3:0] c_ST_IF      = 4'd0;
    localparam logic [3:0] c_ST_DEC     = 4'd1;
    localparam logic [3:0] c_ST_EXEC_R  = 4'd2;
    localparam logic [3:0] c_ST_EXEC_I  = 4'd3;
    localparam logic [3:0] c_ST_ADDR_LD = 4'd4;
    localparam logic [3:0] c_ST_ADDR_ST = 4'd5;
    localparam logic [3:0] c_ST_MEM_RD  = 4'd6;
    localparam logic [3:0] c_ST_MEM_WR  = 4'd7;
    localparam logic [3:0] c_ST_WB_ALU  = 4'd8;
    localparam logic [3:0] c_ST_WB_MEM  = 4'd9;
    localparam logic [3:0] c_ST_PC_UPD  = 4'd10;
    localparam logic [3:0] c_ST_BRANCH  = 4'd11;

    localparam logic [5:0] c_OP_RTYPE = 6'b100000;
    localparam logic [5:0] c_OP_LI    = 6'b111000;
    localparam logic [5:0] c_OP_LUI   = 6'b111001;
    localparam logic [5:0] c_OP_ADDI  = 6'b110000;
    localparam logic [5:0] c_OP_ANDI  = 6'b110010;
    localparam logic [5:0] c_OP_ORI   = 6'b110011;
    localparam logic [5:0] c_OP_LB    = 6'b000011;
    localparam logic [5:0] c_OP_LW    = 6'b001111;
    localparam logic [5:0] c_OP_SB    = 6'b000111;
    localparam logic [5:0] c_OP_SW    = 6'b011111;
    localparam logic [5:0] c_OP_BEQ   = 6'b000000;
    localparam logic [5:0] c_OP_BNE   = 6'b000001;
    localparam logic [5:0] c_OP_B     = 6'b111111;

    localparam logic [3:0] c_WAIT_LAST = 4'(MEM_WAIT - 1);

    logic [3:0] r_state;
    logic [3:0] r_cnt;
    logic [5:0] r_opcode;
    logic [3:0] r_func;

    logic [3:0] w_next;
    logic [3:0] w_cnt_next;
    logic       w_cnt_done;
    logic [5:0] w_dec_op;
    logic       w_unused;

    logic       w_pc_ld;
    logic       w_pc_sel;
    logic       w_ir_ld;
    logic       w_rf_wr;
    logic       w_rf_wds;
    logic       w_rf_b_sel;
    logic       w_bin_sel;
    logic [3:0] w_alu_func;
    logic [1:0] w_imm_sel;
    logic       w_mem_wr;
    logic       w_byte;

    assign w_dec_op   = Instr[31:26];
    assign w_unused   = ^Instr[25:4];
    assign w_cnt_done = (r_cnt == c_WAIT_LAST);

    // Every state change restarts the wait counter so each multi-cycle state begins at 0.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next != r_state) begin
            w_cnt_next = 4'd0;
        end else if (!w_cnt_done) begin
            w_cnt_next = r_cnt + 4'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= c_ST_IF;
            r_cnt    <= 4'd0;
            r_opcode <= 6'd0;
            r_func   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == c_ST_DEC) begin
                r_opcode <= Instr[31:26];
                r_func   <= Instr[3:0];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pc_ld    = 1'b0;
        w_pc_sel   = 1'b0;
        w_ir_ld    = 1'b0;
        w_rf_wr    = 1'b0;
        w_rf_wds   = 1'b0;
        w_rf_b_sel = 1'b0;
        w_bin_sel  = 1'b0;
        w_alu_func = 4'b0000;
        w_imm_sel  = 2'b00;
        w_mem_wr   = 1'b0;
        w_byte     = 1'b0;
        case (r_state)
            c_ST_IF: begin
                w_ir_ld = 1'b1;
                if (w_cnt_done) w_next = c_ST_DEC;
            end
            c_ST_DEC: begin
                case (w_dec_op)
                    c_OP_RTYPE:                                      w_next = c_ST_EXEC_R;
                    c_OP_LI, c_OP_LUI, c_OP_ADDI, c_OP_ANDI, c_OP_ORI: w_next = c_ST_EXEC_I;
                    c_OP_LB, c_OP_LW:                                w_next = c_ST_ADDR_LD;
                    c_OP_SB, c_OP_SW:                                w_next = c_ST_ADDR_ST;
                    c_OP_BEQ, c_OP_BNE, c_OP_B:                      w_next = c_ST_BRANCH;
                    default: begin
                        // Unknown opcode: skip it by advancing to PC+4.
                        w_next  = c_ST_IF;
                        w_pc_ld = 1'b1;
                    end
                endcase
            end
            c_ST_EXEC_R: begin
                w_alu_func = r_func;
                w_next     = c_ST_WB_ALU;
            end
            c_ST_EXEC_I: begin
                // li/lui rely on the datapath supplying R0 as operand A.
                w_bin_sel = 1'b1;
                case (r_opcode)
                    c_OP_ANDI: begin w_imm_sel = 2'b01; w_alu_func = 4'b0010; end
                    c_OP_ORI:  begin w_imm_sel = 2'b01; w_alu_func = 4'b0011; end
                    c_OP_LUI:  w_imm_sel = 2'b10;
                    default:   w_imm_sel = 2'b00;
                endcase
                w_next = c_ST_WB_ALU;
            end
            c_ST_ADDR_LD: begin
                w_bin_sel = 1'b1;
                w_next    = c_ST_MEM_RD;
            end
            c_ST_ADDR_ST: begin
                w_bin_sel = 1'b1;
                w_next    = c_ST_MEM_WR;
            end
            c_ST_MEM_RD: begin
                w_byte = (r_opcode == c_OP_LB);
                if (w_cnt_done) w_next = c_ST_WB_MEM;
            end
            c_ST_MEM_WR: begin
                w_mem_wr   = 1'b1;
                w_rf_b_sel = 1'b1;
                w_byte     = (r_opcode == c_OP_SB);
                if (w_cnt_done) w_next = c_ST_PC_UPD;
            end
            c_ST_WB_ALU: begin
                w_rf_wr = 1'b1;
                w_pc_ld = 1'b1;
                w_next  = c_ST_IF;
            end
            c_ST_WB_MEM: begin
                w_rf_wr  = 1'b1;
                w_rf_wds = 1'b1;
                w_pc_ld  = 1'b1;
                w_next   = c_ST_IF;
            end
            c_ST_PC_UPD: begin
                w_pc_ld = 1'b1;
                w_next  = c_ST_IF;
            end
            c_ST_BRANCH: begin
                w_imm_sel  = 2'b11;
                w_alu_func = 4'b0001;
                w_rf_b_sel = 1'b1;
                w_pc_ld    = 1'b1;
                w_pc_sel   = (r_opcode == c_OP_B) ||
                             ((r_opcode == c_OP_BEQ) &&  ALU_zero) ||
                             ((r_opcode == c_OP_BNE) && !ALU_zero);
                w_next     = c_ST_IF;
            end
            default: w_next = c_ST_IF;
        endcase
    end

    // Outputs are forced quiet while Reset is held, including mid-access.
    assign PC_LdEn       = w_pc_ld    & ~Reset;
    assign PC_sel        = w_pc_sel   & ~Reset;
    assign IR_LdEn       = w_ir_ld    & ~Reset;
    assign RF_WrEn       = w_rf_wr    & ~Reset;
    assign RF_WrData_sel = w_rf_wds   & ~Reset;
    assign RF_B_sel      = w_rf_b_sel & ~Reset;
    assign ALU_Bin_sel   = w_bin_sel  & ~Reset;
    assign ALU_func      = Reset ? 4'b0000 : w_alu_func;
    assign ImmExt_sel    = Reset ? 2'b00   : w_imm_sel;
    assign MEM_WrEn      = w_mem_wr   & ~Reset;
    assign ByteOp        = w_byte     & ~Reset;

endmodule

`default_nettype wire
